cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001: Parameter NUM_SETS, 8, number of sets; index width is log2(NUM_SETS); only 8 SHALL be supported.
REQ-002: Parameter TAG_W, 25, tag width; address split SHALL be tag[31:7], index[6:4], offset[3:0].
REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: cpu_req  input  1  CPU access request, held high until cpu_ready.
REQ-006: cpu_addr  input  32  access address, sampled at acceptance.
REQ-007: cpu_ready  output  1  one-cycle pulse: access complete.
REQ-008: cpu_hit  output  1  valid with cpu_ready: 1 = first-lookup hit, 0 = serviced after refill.
REQ-009: tag_q  input  100  four way tag outputs at set_idx, way w at bits [25w+24:25w].
REQ-010: valid_q  input  4  per-way valid bits at set_idx.
REQ-011: set_idx  output  3  set index driven to the tag and valid arrays.
REQ-012: tag_d  output  25  tag write data.
REQ-013: tag_we  output  1  tag/valid write strobe, drives memWrite of all ways.
REQ-014: way_sel  output  4  one-hot way enable, drives the per-way decOut1b.
REQ-015: mem_req  output  1  line refill request to next level.
REQ-016: mem_addr  output  32  refill line address, offset bits forced to 0.
REQ-017: mem_ack  input  1  refill complete, single-cycle pulse.
REQ-018: miss_cnt  output  16  saturating count of misses.

Function
REQ-019: The FSM SHALL have states IDLE, LOOKUP, MISS, UPDATE.
REQ-020: In IDLE with cpu_req=1, the block SHALL latch cpu_addr and enter LOOKUP on the next edge.
REQ-021: In LOOKUP, way w SHALL hit when valid_q[w]=1 and its tag_q slice equals the latched tag.
REQ-022: On a LOOKUP hit, cpu_ready SHALL pulse in the LOOKUP cycle and the FSM SHALL return to IDLE; hit latency is 2 cycles from acceptance.
REQ-023: If more than one way matches, the lowest-index way SHALL be reported; no error is flagged.
REQ-024: On a LOOKUP miss, the FSM SHALL enter MISS, choose a victim, and increment miss_cnt, which holds at 16'hFFFF.
REQ-025: Victim choice SHALL be the lowest-index invalid way; if all ways are valid, the replacement policy (REQ-034/035) SHALL decide.
REQ-026: In MISS, mem_req SHALL be high with mem_addr = {tag,index,4'b0}; on mem_ack=1 the FSM SHALL enter UPDATE, and mem_ack in the first MISS cycle SHALL be accepted.
REQ-027: In UPDATE, tag_we SHALL be 1 for exactly one cycle, with way_sel = one-hot victim and tag_d = latched tag; the array sets valid in the same write.
REQ-028: After UPDATE, the FSM SHALL re-enter LOOKUP; the resulting hit SHALL pulse cpu_ready with cpu_hit=0.
REQ-029: set_idx SHALL equal the latched index outside IDLE and cpu_addr[6:4] in IDLE.
REQ-030: tag_we, way_sel and mem_req SHALL be 0 in all states except those given above.
REQ-031: cpu_req changes while the FSM is busy SHALL be ignored; cpu_addr is not resampled.
REQ-032: mem_ack outside MISS SHALL be ignored.

Reset
REQ-033: Reset SHALL force state=IDLE, cpu_ready=0, cpu_hit=0, tag_we=0, way_sel=0, mem_req=0, mem_addr=0, miss_cnt=0, and all replacement state=0, asynchronously and including mid-refill.

Configuration
REQ-034: Macro CACHE_CTRL_PLRU_EN defined: each set SHALL hold a 3-bit tree pseudo-LRU, updated on every hit and every UPDATE; the victim is the way the tree points away from.
REQ-035: Macro not defined: each set SHALL hold a 2-bit round-robin pointer, advanced only on UPDATE of a fully valid set, wrapping 3->0; the victim is the pointer value.

Verification
REQ-036: Reset, then cpu_req with addr 0x0000_0010 -> miss; mem_req with mem_addr 0x0000_0010; mem_ack after 3 cycles -> tag_we with way_sel=0001, then cpu_ready with cpu_hit=0, miss_cnt=1.
REQ-037: Repeat the same address -> cpu_ready 2 cycles after acceptance with cpu_hit=1 and no mem_req.
REQ-038: Fill set 1 with tags 1..4, then access tag 5 -> round-robin victim way_sel=0001; tag 6 -> 0010 (PLRU build: victim per tree after hits).
REQ-039: Assert reset while in MISS -> mem_req drops in the same cycle, state=IDLE, miss_cnt=0.
REQ-040: mem_ack in the same cycle mem_req first rises -> UPDATE on the next cycle and total miss latency of 5 cycles.
REQ-041: Preload two ways of one set with the same tag -> hit reported and lowest way used.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-way set-associative cache whose
// tag and valid arrays live outside this block. Accepts one CPU access at a
// time, looks the tag up, and on a miss requests a line refill, writes the
// new tag into the chosen victim way and repeats the lookup.
//
// Optional feature macro: CACHE_CTRL_PLRU_EN
//   defined     -> 3-bit tree pseudo-LRU per set
//   not defined -> 2-bit round-robin pointer per set (default build)
//
// state  | meaning
// IDLE   | waiting for cpu_req; set_idx follows cpu_addr
// LOOKUP | compare four ways against the latched tag
// MISS   | refill requested, waiting for mem_ack
// UPDATE | one-cycle tag/valid write into the victim way
module cache_ctrl #(
    parameter int NUM_SETS = 8,
    parameter int TAG_W    = 25
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic [31:0]                 cpu_addr,
    output logic                        cpu_ready,
    output logic                        cpu_hit,
    input  logic [4*TAG_W-1:0]          tag_q,
    input  logic [3:0]                  valid_q,
    output logic [$clog2(NUM_SETS)-1:0] set_idx,
    output logic [TAG_W-1:0]            tag_d,
    output logic                        tag_we,
    output logic [3:0]                  way_sel,
    output logic                        mem_req,
    output logic [31:0]                 mem_addr,
    input  logic                        mem_ack,
    output logic [15:0]                 miss_cnt
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFF_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [IDX_W-1:0]   req_idx_q, req_idx_d;
    logic               refill_q, refill_d;
    logic [1:0]         victim_q, victim_d;
    logic               full_q, full_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    logic               hit_any;
    logic [1:0]         hit_way;
    logic               inv_any;
    logic [1:0]         inv_way;
    logic [1:0]         repl_way;

    // The line offset never reaches the tag arrays or the refill address.
    logic               unused_offset;
    assign unused_offset = ^cpu_addr[OFF_W-1:0];

    // Way compare and lowest-invalid search; descending loops let the lowest index win.
    always_comb begin
        hit_any = 1'b0;
        hit_way = 2'd0;
        inv_any = 1'b0;
        inv_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (valid_q[w] && (tag_q[w*TAG_W +: TAG_W] == req_tag_q)) begin
                hit_any = 1'b1;
                hit_way = 2'(w);
            end
            if (!valid_q[w]) begin
                inv_any = 1'b1;
                inv_way = 2'(w);
            end
        end
    end

`ifdef CACHE_CTRL_PLRU_EN
    // Tree bits: [0]=1 -> right pair (ways 2/3) more recent,
    // [1]=1 -> way 1 newer than way 0, [2]=1 -> way 3 newer than way 2.
    logic [NUM_SETS-1:0][2:0] plru_q;
    logic [2:0]               plru_cur;
    logic [2:0]               plru_nxt;
    logic                     touch_en;
    logic [1:0]               touch_way;
    logic                     unused_full;

    assign unused_full = full_q;
    assign plru_cur    = plru_q[req_idx_q];

    // Victim is the leaf the tree points away from.
    always_comb begin
        repl_way = plru_cur[0] ? {1'b0, ~plru_cur[1]} : {1'b1, ~plru_cur[2]};
    end

    // Every hit and every refill write marks the touched way most recent.
    always_comb begin
        touch_en  = 1'b0;
        touch_way = victim_q;
        if (state_q == LOOKUP && hit_any) begin
            touch_en  = 1'b1;
            touch_way = hit_way;
        end else if (state_q == UPDATE) begin
            touch_en  = 1'b1;
        end
        plru_nxt    = plru_cur;
        plru_nxt[0] = touch_way[1];
        if (touch_way[1]) begin
            plru_nxt[2] = touch_way[0];
        end else begin
            plru_nxt[1] = touch_way[0];
        end
    end

    // Per-set tree storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plru_q <= '0;
        end else if (touch_en) begin
            plru_q[req_idx_q] <= plru_nxt;
        end
    end
`else
    logic [NUM_SETS-1:0][1:0] rr_q;
    logic                     unused_hit_way;

    assign unused_hit_way = ^hit_way;

    // Victim among fully valid ways is simply the pointer.
    always_comb begin
        repl_way = rr_q[req_idx_q];
    end

    // Pointer moves only when a full set had a line evicted; 2-bit add wraps 3->0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else if (state_q == UPDATE && full_q) begin
            rr_q[req_idx_q] <= rr_q[req_idx_q] + 2'd1;
        end
    end
`endif

    // Next-state, datapath captures and Moore/Mealy outputs of the sequencer.
    always_comb begin
        state_d    = state_q;
        req_tag_d  = req_tag_q;
        req_idx_d  = req_idx_q;
        refill_d   = refill_q;
        victim_d   = victim_q;
        full_d     = full_q;
        miss_cnt_d = miss_cnt_q;
        mem_addr_d = mem_addr_q;
        cpu_ready  = 1'b0;
        cpu_hit    = 1'b0;
        tag_we     = 1'b0;
        way_sel    = 4'b0000;
        mem_req    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    req_tag_d = cpu_addr[31 -: TAG_W];
                    req_idx_d = cpu_addr[OFF_W +: IDX_W];
                    refill_d  = 1'b0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    cpu_ready = 1'b1;
                    cpu_hit   = ~refill_q;
                    state_d   = IDLE;
                end else begin
                    victim_d   = inv_any ? inv_way : repl_way;
                    full_d     = ~inv_any;
                    miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                    mem_addr_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                    state_d    = MISS;
                end
            end
            MISS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                tag_we   = 1'b1;
                way_sel  = 4'b0001 << victim_q;
                refill_d = 1'b1;
                state_d  = LOOKUP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            refill_q   <= 1'b0;
            victim_q   <= 2'd0;
            full_q     <= 1'b0;
            miss_cnt_q <= 16'd0;
            mem_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_tag_q  <= req_tag_d;
            req_idx_q  <= req_idx_d;
            refill_q   <= refill_d;
            victim_q   <= victim_d;
            full_q     <= full_d;
            miss_cnt_q <= miss_cnt_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign set_idx  = (state_q == IDLE) ? cpu_addr[OFF_W +: IDX_W] : req_idx_q;
    assign tag_d    = req_tag_q;
    assign mem_addr = mem_addr_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed, table-driven bench for cache_ctrl (default round-robin build).
// Holds a behavioural tag/valid array that answers set_idx and takes tag_we writes.
module tb_cache_ctrl;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         cpu_ready;
    logic         cpu_hit;
    logic [99:0]  tag_q;
    logic [3:0]   valid_q;
    logic [2:0]   set_idx;
    logic [24:0]  tag_d;
    logic         tag_we;
    logic [3:0]   way_sel;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [15:0]  miss_cnt;

    int checks   = 0;
    int failures = 0;

    cache_ctrl #(.NUM_SETS(8), .TAG_W(25)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .tag_q     (tag_q),
        .valid_q   (valid_q),
        .set_idx   (set_idx),
        .tag_d     (tag_d),
        .tag_we    (tag_we),
        .way_sel   (way_sel),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .miss_cnt  (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    // Behavioural tag/valid array
    logic [24:0] m_tag [8][4];
    logic        m_val [8][4];
    logic        arr_clr;
    logic        pl_en;
    logic [2:0]  pl_set;
    logic [1:0]  pl_way;
    logic [24:0] pl_tag;
    logic        pl_val;

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int s = 0; s < 8; s++) begin
                for (int w = 0; w < 4; w++) begin
                    m_val[s][w] <= 1'b0;
                    m_tag[s][w] <= '0;
                end
            end
        end else if (pl_en) begin
            m_tag[pl_set][pl_way] <= pl_tag;
            m_val[pl_set][pl_way] <= pl_val;
        end else if (tag_we) begin
            for (int w = 0; w < 4; w++) begin
                if (way_sel[w]) begin
                    m_tag[set_idx][w] <= tag_d;
                    m_val[set_idx][w] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        tag_q   = '0;
        valid_q = '0;
        for (int w = 0; w < 4; w++) begin
            tag_q[w*25 +: 25] = m_tag[set_idx][w];
            valid_q[w]        = m_val[set_idx][w];
        end
    end

    typedef struct {
        bit          rst;
        logic [31:0] addr;
        int          delay;
        bit          spur;
        bit          wiggle;
        bit          exp_hit;
        logic [3:0]  exp_way;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_and_clear();
        @(negedge clk);
        reset   = 1'b1;
        arr_clr = 1'b1;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        arr_clr = 1'b0;
    endtask

    task automatic preload(input logic [2:0] s, input logic [1:0] w, input logic [24:0] t, input logic v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_set = s;
        pl_way = w;
        pl_tag = t;
        pl_val = v;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // One full CPU access; cycle 1 is the IDLE cycle in which the request is presented.
    task automatic do_access(input vec_t v, output int lat, output logic hit, output logic mem_seen,
                             output logic [31:0] maddr, output logic [3:0] way, output int we_cnt,
                             output logic timeout);
        int  cyc;
        int  mcyc;
        bit  done;
        lat      = 0;
        hit      = 1'b0;
        mem_seen = 1'b0;
        maddr    = '0;
        way      = '0;
        we_cnt   = 0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = v.addr;
        mem_ack  = v.spur;
        cyc      = 1;
        mcyc     = 0;
        done     = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (v.wiggle) begin
                cpu_addr = ~v.addr;
                cpu_req  = 1'b0;
            end
            if (mem_req) begin
                mem_seen = 1'b1;
                maddr    = mem_addr;
                if (mcyc == v.delay) mem_ack = 1'b1;
                mcyc++;
            end else begin
                mem_ack = v.spur;
            end
            if (tag_we) begin
                way = way_sel;
                we_cnt++;
            end
            if (cpu_ready) begin
                hit  = cpu_hit;
                lat  = cyc;
                done = 1'b1;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        timeout = !done;
    endtask

    task automatic run_vec(input vec_t v, input string id);
        int          lat;
        logic        hit;
        logic        mem_seen;
        logic [31:0] maddr;
        logic [3:0]  way;
        int          we_cnt;
        logic        timeout;
        int          exp_lat;
        if (v.rst) reset_and_clear();
        do_access(v, lat, hit, mem_seen, maddr, way, we_cnt, timeout);
        exp_lat = v.exp_hit ? 2 : 5 + v.delay;
        chk({id, "_timeout"}, 32'(timeout), 32'd0);
        chk({id, "_cpu_hit"}, 32'(hit), 32'(v.exp_hit));
        chk({id, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({id, "_mem_req_seen"}, 32'(mem_seen), 32'(!v.exp_hit));
        if (!v.exp_hit) chk({id, "_mem_addr"}, maddr, {v.addr[31:4], 4'h0});
        chk({id, "_way_sel"}, 32'(way), 32'(v.exp_way));
        chk({id, "_tag_we_cycles"}, 32'(we_cnt), v.exp_hit ? 32'd0 : 32'd1);
        chk({id, "_miss_cnt"}, 32'(miss_cnt), 32'(v.exp_cnt));
    endtask

    initial begin
        vec_t v;
        int   n;

        //          rst  addr           dly spur wig  hit  way      cnt
        tbl[0]  = '{1'b0, 32'h0000_0010, 3, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd1};
        tbl[1]  = '{1'b0, 32'h0000_0010, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd1};
        tbl[2]  = '{1'b0, 32'h0000_0014, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd1};
        tbl[3]  = '{1'b0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd2};
        tbl[4]  = '{1'b0, 32'h0000_0024, 0, 1'b1, 1'b0, 1'b1, 4'b0000, 16'd2};
        tbl[5]  = '{1'b0, 32'h0000_0030, 1, 1'b0, 1'b1, 1'b0, 4'b0001, 16'd3};
        tbl[6]  = '{1'b0, 32'h0000_0030, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd3};
        tbl[7]  = '{1'b0, 32'h1234_5640, 2, 1'b1, 1'b0, 1'b0, 4'b0001, 16'd4};
        tbl[8]  = '{1'b1, 32'h0000_0090, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd1};
        tbl[9]  = '{1'b0, 32'h0000_0110, 1, 1'b0, 1'b0, 1'b0, 4'b0010, 16'd2};
        tbl[10] = '{1'b0, 32'h0000_0190, 0, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd3};
        tbl[11] = '{1'b0, 32'h0000_0210, 2, 1'b0, 1'b0, 1'b0, 4'b1000, 16'd4};
        tbl[12] = '{1'b0, 32'h0000_0090, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd4};
        tbl[13] = '{1'b0, 32'h0000_0290, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd5};
        tbl[14] = '{1'b0, 32'h0000_0310, 1, 1'b0, 1'b0, 1'b0, 4'b0010, 16'd6};
        tbl[15] = '{1'b0, 32'h0000_0110, 0, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd7};
        tbl[16] = '{1'b0, 32'h0000_0090, 0, 1'b0, 1'b0, 1'b0, 4'b1000, 16'd8};
        tbl[17] = '{1'b0, 32'h0000_0290, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd8};
        tbl[18] = '{1'b0, 32'h0000_0390, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd9};

        reset    = 1'b1;
        arr_clr  = 1'b1;
        pl_en    = 1'b0;
        pl_set   = '0;
        pl_way   = '0;
        pl_tag   = '0;
        pl_val   = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = 32'h0000_0050;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_hit",   32'(cpu_hit),   32'd0);
        chk("rst_tag_we",    32'(tag_we),    32'd0);
        chk("rst_way_sel",   32'(way_sel),   32'd0);
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_miss_cnt",  32'(miss_cnt),  32'd0);
        chk("idle_set_idx",  32'(set_idx),   32'd5);
        reset   = 1'b0;
        arr_clr = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Same tag in two valid ways (plus an invalid way 0 with that tag): must hit.
        reset_and_clear();
        preload(3'd3, 2'd0, 25'd9, 1'b0);
        preload(3'd3, 2'd1, 25'd9, 1'b1);
        preload(3'd3, 2'd2, 25'd9, 1'b1);
        v = '{1'b0, 32'h0000_04B0, 0, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd0};
        run_vec(v, "dup_hit");
        v = '{1'b0, 32'h0000_0530, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd1};
        run_vec(v, "dup_set_miss");

        // Reset asserted mid-refill: outputs fall without waiting for a clock edge.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0040;
        mem_ack  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk("rm_mem_req_high", 32'(mem_req), 32'd1);
        chk("rm_mem_addr",     mem_addr,     32'h0000_0040);
        chk("rm_cnt_before",   32'(miss_cnt), 32'd2);
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("rm_mem_req_low",  32'(mem_req),   32'd0);
        chk("rm_miss_cnt",     32'(miss_cnt),  32'd0);
        chk("rm_mem_addr_clr", mem_addr,       32'd0);
        chk("rm_cpu_ready",    32'(cpu_ready), 32'd0);
        chk("rm_tag_we",       32'(tag_we),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        v = '{1'b0, 32'h0000_0040, 0, 1'b0, 1'b0, 1'b0, 4'b0001, 16'd1};
        run_vec(v, "rm_retry");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
